// File: rtl/multisim_server_chan_if.sv
// Handshake bundle for one multisim server channel: client link rx/tx and RTL pull/push streams.
// slave = the channel endpoint, master = the client link plus RTL peers driving it.
interface multisim_server_chan_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  link_rx_vld;
    logic [DATA_WIDTH-1:0] link_rx_data;
    logic                  link_rx_rdy;
    logic                  data_pull_rdy;
    logic                  data_pull_vld;
    logic [DATA_WIDTH-1:0] data_pull;
    logic                  data_push_vld;
    logic [DATA_WIDTH-1:0] data_push;
    logic                  data_push_rdy;
    logic                  link_tx_vld;
    logic [DATA_WIDTH-1:0] link_tx_data;
    logic                  link_tx_rdy;

    modport slave (
        input  link_rx_vld, link_rx_data, data_pull_rdy, data_push_vld, data_push, link_tx_rdy,
        output link_rx_rdy, data_pull_vld, data_pull, data_push_rdy, link_tx_vld, link_tx_data
    );

    modport master (
        output link_rx_vld, link_rx_data, data_pull_rdy, data_push_vld, data_push, link_tx_rdy,
        input  link_rx_rdy, data_pull_vld, data_pull, data_push_rdy, link_tx_vld, link_tx_data
    );
endinterface

// File: rtl/multisim_server_chan.sv
// Server-side multisim channel endpoint: FIFO P (client -> RTL) and FIFO T (RTL -> client), gated by connected.
// Define MULTISIM_SERVER_STATS_EN to add the 32-bit pull_count/push_count handshake counters.
module multisim_server_chan #(
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  connected,
    multisim_server_chan_if.slave bus
`ifdef MULTISIM_SERVER_STATS_EN
    ,
    output logic [31:0]           pull_count,
    output logic [31:0]           push_count
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [DATA_WIDTH-1:0] p_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] t_mem [FIFO_DEPTH];
    logic [PW-1:0]         p_wr, p_rd, t_wr, t_rd;
    logic                  p_full, p_empty, t_full, t_empty;
    logic                  p_push, p_pop, t_push, t_pop;
    logic                  rx_rdy, pull_vld, push_rdy, tx_vld;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign p_empty = (p_wr == p_rd);
    assign p_full  = (p_wr == {~p_rd[AW], p_rd[AW-1:0]});
    assign t_empty = (t_wr == t_rd);
    assign t_full  = (t_wr == {~t_rd[AW], t_rd[AW-1:0]});

    assign rx_rdy   = connected && !p_full;
    assign pull_vld = !p_empty;
    assign push_rdy = connected && !t_full;
    assign tx_vld   = connected && !t_empty;

    assign p_push = bus.link_rx_vld && rx_rdy;
    assign p_pop  = bus.data_pull_rdy && pull_vld;
    assign t_push = bus.data_push_vld && push_rdy;
    assign t_pop  = bus.link_tx_rdy && tx_vld;

    assign bus.link_rx_rdy   = rx_rdy;
    assign bus.data_pull_vld = pull_vld;
    assign bus.data_pull     = pull_vld ? p_mem[p_rd[AW-1:0]] : '0;
    assign bus.data_push_rdy = push_rdy;
    assign bus.link_tx_vld   = tx_vld;
    assign bus.link_tx_data  = tx_vld ? t_mem[t_rd[AW-1:0]] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_wr <= '0;
            p_rd <= '0;
            t_wr <= '0;
            t_rd <= '0;
        end else begin
            if (p_push) p_wr <= p_wr + PTR_ONE;
            if (p_pop)  p_rd <= p_rd + PTR_ONE;
            if (t_push) t_wr <= t_wr + PTR_ONE;
            if (t_pop)  t_rd <= t_rd + PTR_ONE;
        end
    end

    // Storage is not reset: the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (p_push) p_mem[p_wr[AW-1:0]] <= bus.link_rx_data;
        if (t_push) t_mem[t_wr[AW-1:0]] <= bus.data_push;
    end

`ifdef MULTISIM_SERVER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pull_count <= '0;
            push_count <= '0;
        end else begin
            if (p_pop) pull_count <= pull_count + 32'd1;
            if (t_pop) push_count <= push_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_multisim_server_chan.sv
// Bench for multisim_server_chan: queue-based reference model checked every cycle, directed scenarios, random traffic.
module tb_multisim_server_chan;
    localparam int DW    = 64;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    logic connected;
`ifdef MULTISIM_SERVER_STATS_EN
    logic [31:0] pull_count;
    logic [31:0] push_count;
`endif

    multisim_server_chan_if #(.DATA_WIDTH(DW)) bus ();

    multisim_server_chan #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .connected (connected),
        .bus       (bus)
`ifdef MULTISIM_SERVER_STATS_EN
        ,
        .pull_count(pull_count),
        .push_count(push_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [63:0] pq[$];
    logic [63:0] tq[$];
    int unsigned m_pull_cnt = 0;
    int unsigned m_push_cnt = 0;
    bit          m_rx_hs, m_pull_hs, m_push_hs, m_tx_hs;
    logic        e_pv, e_tv;
    logic [63:0] e_pd, e_td;
    logic [63:0] pw[5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: two bounded queues; a handshake happens when both sides agree at a rising edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pq.delete();
            tq.delete();
            m_pull_cnt = 0;
            m_push_cnt = 0;
        end else begin
            m_rx_hs   = bus.link_rx_vld && connected && (pq.size() < DEPTH);
            m_pull_hs = bus.data_pull_rdy && (pq.size() > 0);
            m_push_hs = bus.data_push_vld && connected && (tq.size() < DEPTH);
            m_tx_hs   = bus.link_tx_rdy && connected && (tq.size() > 0);
            if (m_pull_hs) begin void'(pq.pop_front()); m_pull_cnt++; end
            if (m_tx_hs)   begin void'(tq.pop_front()); m_push_cnt++; end
            if (m_rx_hs)   pq.push_back(bus.link_rx_data);
            if (m_push_hs) tq.push_back(bus.data_push);
        end
    end

    always @(negedge clk) begin
        e_pv = (pq.size() != 0);
        e_pd = e_pv ? pq[0] : 64'd0;
        e_tv = connected && (tq.size() != 0);
        e_td = e_tv ? tq[0] : 64'd0;
        chk("model_link_rx_rdy",   bus.link_rx_rdy,   connected && (pq.size() < DEPTH));
        chk("model_data_push_rdy", bus.data_push_rdy, connected && (tq.size() < DEPTH));
        chk("model_data_pull_vld", bus.data_pull_vld, e_pv);
        chk("model_data_pull",     bus.data_pull,     e_pd);
        chk("model_link_tx_vld",   bus.link_tx_vld,   e_tv);
        chk("model_link_tx_data",  bus.link_tx_data,  e_td);
`ifdef MULTISIM_SERVER_STATS_EN
        chk("model_pull_count", pull_count, m_pull_cnt);
        chk("model_push_count", push_count, m_push_cnt);
`endif
    end

    initial begin
        pw[0] = 64'hcafedeca_deadbeef;
        pw[1] = 64'h1111_0000_0000_0001;
        pw[2] = 64'h2222_0000_0000_0002;
        pw[3] = 64'h3333_0000_0000_0003;
        pw[4] = 64'h4444_0000_0000_0004;
        rst = 1'b1;
        connected = 1'b1;
        bus.link_rx_vld   = 1'b0;
        bus.link_rx_data  = '0;
        bus.data_pull_rdy = 1'b0;
        bus.data_push_vld = 1'b0;
        bus.data_push     = '0;
        bus.link_tx_rdy   = 1'b0;

        @(negedge clk);
        chk("rst_link_rx_rdy",   bus.link_rx_rdy,   64'd1);
        chk("rst_data_push_rdy", bus.data_push_rdy, 64'd1);
        chk("rst_data_pull_vld", bus.data_pull_vld, 64'd0);
        chk("rst_data_pull",     bus.data_pull,     64'd0);
        chk("rst_link_tx_vld",   bus.link_tx_vld,   64'd0);
        chk("rst_link_tx_data",  bus.link_tx_data,  64'd0);
        tick();
        rst = 1'b0;

        // Pull path: 1, 2, 3 back to back, consumer always ready.
        bus.data_pull_rdy = 1'b1;
        bus.link_rx_vld   = 1'b1;
        bus.link_rx_data  = 64'd1;
        tick(); bus.link_rx_data = 64'd2;
        @(negedge clk); chk("pull_w1", bus.data_pull, 64'd1);
        tick(); bus.link_rx_data = 64'd3;
        @(negedge clk); chk("pull_w2", bus.data_pull, 64'd2);
        tick(); bus.link_rx_vld = 1'b0;
        @(negedge clk); chk("pull_w3", bus.data_pull, 64'd3);
        tick();
        @(negedge clk); chk("pull_drained_vld", bus.data_pull_vld, 64'd0);

        // Push path stalled by the client, then released.
        bus.link_tx_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.data_push_vld = 1'b1;
            bus.data_push     = pw[i];
            tick();
        end
        bus.data_push = pw[4];
        @(negedge clk);
        chk("push_full_rdy",  bus.data_push_rdy, 64'd0);
        chk("push_full_head", bus.link_tx_data,  pw[0]);
        tick();
        bus.data_push_vld = 1'b0;
        bus.link_tx_rdy   = 1'b1;
        @(negedge clk);
        chk("push_refused_rdy", bus.data_push_rdy, 64'd0);
        chk("push_release_w0",  bus.link_tx_data,  pw[0]);
        for (int i = 1; i < 4; i++) begin
            tick();
            @(negedge clk);
            chk("push_release_word", bus.link_tx_data, pw[i]);
            if (i == 1) chk("push_rdy_back", bus.data_push_rdy, 64'd1);
        end
        tick();
        @(negedge clk); chk("push_drained_vld", bus.link_tx_vld, 64'd0);

        // Disconnect with two words parked in T.
        tick();
        bus.link_tx_rdy   = 1'b0;
        bus.data_push_vld = 1'b1;
        bus.data_push     = 64'hAAAA_0000_0000_000A;
        tick(); bus.data_push = 64'hBBBB_0000_0000_000B;
        tick();
        bus.data_push_vld = 1'b0;
        connected         = 1'b0;
        bus.link_tx_rdy   = 1'b1;
        bus.link_rx_vld   = 1'b1;
        bus.link_rx_data  = 64'hdead;
        @(negedge clk);
        chk("disc_link_tx_vld",   bus.link_tx_vld,   64'd0);
        chk("disc_link_rx_rdy",   bus.link_rx_rdy,   64'd0);
        chk("disc_data_push_rdy", bus.data_push_rdy, 64'd0);
        tick(); tick();
        @(negedge clk);
        chk("disc_pull_vld", bus.data_pull_vld, 64'd0);
        chk("disc_tx_hold",  bus.link_tx_vld,   64'd0);
        tick();
        bus.link_rx_vld = 1'b0;
        connected       = 1'b1;
        @(negedge clk); chk("recon_w0", bus.link_tx_data, 64'hAAAA_0000_0000_000A);
        tick();
        @(negedge clk); chk("recon_w1", bus.link_tx_data, 64'hBBBB_0000_0000_000B);
        tick();
        @(negedge clk); chk("recon_drained", bus.link_tx_vld, 64'd0);

        // Simultaneous read/write on P holding two words.
        tick();
        bus.data_pull_rdy = 1'b0;
        bus.link_rx_vld   = 1'b1;
        bus.link_rx_data  = 64'd100;
        tick(); bus.link_rx_data = 64'd101;
        tick();
        bus.data_pull_rdy = 1'b1;
        bus.link_rx_data  = 64'd102;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); chk("rw_head", bus.data_pull, 64'(100 + k));
            tick();
            bus.link_rx_data = 64'(103 + k);
        end
        bus.link_rx_vld = 1'b0;
        @(negedge clk); chk("rw_tail0", bus.data_pull, 64'd110);
        tick();
        @(negedge clk); chk("rw_tail1", bus.data_pull, 64'd111);
        tick();
        @(negedge clk); chk("rw_empty", bus.data_pull_vld, 64'd0);

        // Asynchronous reset with both FIFOs occupied.
        tick();
        bus.data_pull_rdy = 1'b0;
        bus.link_tx_rdy   = 1'b0;
        bus.link_rx_vld   = 1'b1;
        bus.link_rx_data  = 64'h5555;
        bus.data_push_vld = 1'b1;
        bus.data_push     = 64'h6666;
        tick();
        bus.link_rx_vld   = 1'b0;
        bus.data_push_vld = 1'b0;
        #2;
        chk("prerst_pull_vld", bus.data_pull_vld, 64'd1);
        chk("prerst_tx_vld",   bus.link_tx_vld,   64'd1);
        rst = 1'b1;
        #1;
        chk("arst_pull_vld", bus.data_pull_vld, 64'd0);
        chk("arst_tx_vld",   bus.link_tx_vld,   64'd0);
        tick();
        rst = 1'b0;
        bus.data_pull_rdy = 1'b1;
        bus.link_tx_rdy   = 1'b1;
        @(negedge clk);
        chk("postrst_pull",    bus.data_pull,    64'd0);
        chk("postrst_tx_data", bus.link_tx_data, 64'd0);
        tick();
        @(negedge clk);
        chk("postrst_pull_vld", bus.data_pull_vld, 64'd0);
        chk("postrst_tx_vld",   bus.link_tx_vld,   64'd0);

        // Five pulls and seven pushes from a clean start.
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.link_rx_vld   = (i < 5);
            bus.link_rx_data  = 64'(i);
            bus.data_push_vld = 1'b1;
            bus.data_push     = 64'(i + 16);
            tick();
        end
        bus.link_rx_vld   = 1'b0;
        bus.data_push_vld = 1'b0;
        tick(); tick(); tick();
        @(negedge clk);
`ifdef MULTISIM_SERVER_STATS_EN
        chk("stats_pull_count", pull_count, 64'd5);
        chk("stats_push_count", push_count, 64'd7);
`endif
        chk("stats_pull_idle", bus.data_pull_vld, 64'd0);

        // Random traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            tick();
            connected         = ($urandom_range(0, 9) != 0);
            bus.link_rx_vld   = $urandom_range(0, 1);
            bus.link_rx_data  = {$urandom, $urandom};
            bus.data_pull_rdy = ($urandom_range(0, 3) != 0);
            bus.data_push_vld = $urandom_range(0, 1);
            bus.data_push     = {$urandom, $urandom};
            bus.link_tx_rdy   = ($urandom_range(0, 3) != 0);
        end
        tick();
        bus.link_rx_vld   = 1'b0;
        bus.data_push_vld = 1'b0;
        connected         = 1'b1;
        tick(); tick();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
